// File: rtl/add_result_stage_pkg.sv
// Shared types and constants for the add result stage: occupancy states, flag bit
// positions, the stored entry format and the saturation limit helper.
package add_stage_pkg;

    localparam int STAGE_WIDTH     = 16;
    localparam int STAGE_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // One buffered result: the (possibly clamped) sum plus its {Z,N,C,V} flags.
    typedef struct packed {
        logic [STAGE_WIDTH-1:0] sum;
        logic [3:0]             flags;
    } entry_t;

    function automatic logic [STAGE_WIDTH-1:0] satLimit(input logic negative);
        satLimit = negative ? {1'b1, {(STAGE_WIDTH-1){1'b0}}}
                            : {1'b0, {(STAGE_WIDTH-1){1'b1}}};
    endfunction

endpackage

// File: rtl/add_result_stage_if.sv
// Bus between the ripple adder, this stage and its consumer. master = the
// environment that feeds operands and accepts results, slave = the stage itself.
interface add_result_stage_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_a_msb;
    logic                 in_b_msb;
    logic [WIDTH-1:0]     in_sum;
    logic                 in_cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    logic [3:0]           out_flags;
    logic [CNT_WIDTH-1:0] ovf_count;

    modport master (
        output in_valid, in_a_msb, in_b_msb, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_sum, out_flags, ovf_count
    );

    modport slave (
        input  in_valid, in_a_msb, in_b_msb, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_sum, out_flags, ovf_count
    );
endinterface

// File: rtl/add_result_stage_flag_gen.sv
// Combinational flag derivation for one adder result. With ADD_STAGE_SAT_EN defined,
// signed overflows are clamped to the signed limit matching operand A's sign.
module add_flag_gen
    import add_stage_pkg::*;
#(
    parameter int WIDTH = STAGE_WIDTH
) (
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output entry_t           entry_o
);

    logic             overflow;
    logic [WIDTH-1:0] storedSum;

    // Overflow: operands share a sign that the raw sum does not.
    always_comb begin
        overflow = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
`ifdef ADD_STAGE_SAT_EN
        storedSum = overflow ? satLimit(a_msb_i) : sum_i;
`else
        storedSum = sum_i;
`endif
        entry_o              = '0;
        entry_o.sum          = storedSum;
        entry_o.flags[FLG_Z] = (storedSum == '0);
        entry_o.flags[FLG_N] = storedSum[WIDTH-1];
        entry_o.flags[FLG_C] = cout_i;
        entry_o.flags[FLG_V] = overflow;
    end

endmodule

// File: rtl/add_result_stage.sv
// Result register stage behind the 16-bit adder: 2-entry skid buffer with registered
// ready, flag capture and saturating overflow counter. Optional clamp: ADD_STAGE_SAT_EN.
module add_result_stage
    import add_stage_pkg::*;
#(
    parameter int WIDTH     = STAGE_WIDTH,
    parameter int CNT_WIDTH = STAGE_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    add_result_stage_if.slave  bus
);

    occ_t                 state_q;
    occ_t                 state_d;
    logic                 inReady_q;
    entry_t               outEntry_q;
    entry_t               skidEntry_q;
    entry_t               newEntry;
    logic [CNT_WIDTH-1:0] ovfCount_q;

    logic accept;
    logic pop;
    logic outValid;
    logic loadOut;
    logic loadSkid;
    logic outFromSkid;

    add_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .a_msb_i (bus.in_a_msb),
        .b_msb_i (bus.in_b_msb),
        .sum_i   (bus.in_sum),
        .cout_i  (bus.in_cout),
        .entry_o (newEntry)
    );

    assign outValid = (state_q != EMPTY);
    assign accept   = bus.in_valid & inReady_q;
    assign pop      = outValid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (pop && !accept) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // A new result goes straight to the output register unless the head is still
    // waiting; then it parks in the skid register until the head drains.
    always_comb begin
        loadOut     = 1'b0;
        loadSkid    = 1'b0;
        outFromSkid = 1'b0;
        case (state_q)
            EMPTY: loadOut = accept;
            ONE: begin
                loadOut  = accept & pop;
                loadSkid = accept & ~pop;
            end
            FULL: begin
                loadOut     = pop;
                outFromSkid = pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outEntry_q  <= '0;
            skidEntry_q <= '0;
        end else begin
            if (loadOut)  outEntry_q  <= outFromSkid ? skidEntry_q : newEntry;
            if (loadSkid) skidEntry_q <= newEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfCount_q <= '0;
        end else if (accept && newEntry.flags[FLG_V] && (ovfCount_q != '1)) begin
            ovfCount_q <= ovfCount_q + CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid;
    assign bus.out_sum   = outEntry_q.sum;
    assign bus.out_flags = outEntry_q.flags;
    assign bus.ovf_count = ovfCount_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Self-checking bench for add_result_stage: queue model compared every cycle plus
// directed vectors with literal expectations. Honours ADD_STAGE_SAT_EN.
module tb_add_result_stage;
    import add_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_result_stage_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();

    add_result_stage #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] sum;
        logic [3:0]  flags;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        modelQ[$];
    logic [15:0] popLog[$];
    logic [15:0] lastSum;
    logic [3:0]  lastFlags;
    int          modelOvf;
    bit          compareEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Result as the adder's consumer should see it: flags from sign rules on the raw operands.
    function automatic exp_t predict(input logic a, input logic b, input logic [15:0] s,
                                     input logic c);
        exp_t e;
        logic v;
        v = (a == b) && (s[15] != a);
        e.sum = s;
`ifdef ADD_STAGE_SAT_EN
        if (v) e.sum = a ? 16'h8000 : 16'h7FFF;
`endif
        e.flags = {e.sum == 16'h0000, e.sum[15], c, v};
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit   acc;
        bit   pp;
        exp_t e;
        if (!rst_n) begin
            modelQ.delete();
            lastSum   = '0;
            lastFlags = '0;
            modelOvf  = 0;
        end else begin
            acc = bus.in_valid && (modelQ.size() < 2);
            pp  = (modelQ.size() > 0) && bus.out_ready;
            if (pp) void'(modelQ.pop_front());
            if (acc) begin
                e = predict(bus.in_a_msb, bus.in_b_msb, bus.in_sum, bus.in_cout);
                modelQ.push_back(e);
                if (e.flags[0] && modelOvf < 255) modelOvf++;
            end
            if (modelQ.size() > 0) begin
                lastSum   = modelQ[0].sum;
                lastFlags = modelQ[0].flags;
            end
        end
    end

    always @(negedge clk) begin
        if (compareEn && rst_n) begin
            checkOutput("cyc_out_valid", 32'(bus.out_valid), 32'(modelQ.size() > 0));
            checkOutput("cyc_in_ready", 32'(bus.in_ready), 32'(modelQ.size() < 2));
            checkOutput("cyc_out_sum", 32'(bus.out_sum), 32'(lastSum));
            checkOutput("cyc_out_flags", 32'(bus.out_flags), 32'(lastFlags));
            checkOutput("cyc_ovf_count", 32'(bus.ovf_count), 32'(modelOvf));
            if (bus.out_valid && bus.out_ready) popLog.push_back(bus.out_sum);
        end
    end

    task automatic applyStimulus(input logic v, input logic a, input logic b,
                                 input logic [15:0] s, input logic c);
        bus.in_valid = v;
        bus.in_a_msb = v ? a : 1'bx;
        bus.in_b_msb = v ? b : 1'bx;
        bus.in_sum   = v ? s : 16'hxxxx;
        bus.in_cout  = v ? c : 1'bx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        #12;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("rst_out_flags", 32'(bus.out_flags), 32'd0);
        checkOutput("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        compareEn = 1'b1;
        tick();

        // Simple positive add, then a 4-beat back-to-back stream.
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0005, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t2_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t2_out_sum", 32'(bus.out_sum), 32'h0005);
        checkOutput("t2_out_flags", 32'(bus.out_flags), 32'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 1'b0);
        tick();
        popLog.delete();
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010 + 16'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("t2_stream_count", 32'(popLog.size()), 32'd4);
        for (int i = 0; i < 4 && i < popLog.size(); i++)
            checkOutput("t2_stream_data", 32'(popLog[i]), 32'h10 + 32'(i));

        // Positive + positive overflowing into the sign bit.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h8000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
`ifdef ADD_STAGE_SAT_EN
        checkOutput("t3_out_sum", 32'(bus.out_sum), 32'h7FFF);
        checkOutput("t3_out_flags", 32'(bus.out_flags), 32'b0001);
`else
        checkOutput("t3_out_sum", 32'(bus.out_sum), 32'h8000);
        checkOutput("t3_out_flags", 32'(bus.out_flags), 32'b0101);
`endif
        checkOutput("t3_ovf_count", 32'(bus.ovf_count), 32'd1);

        // Mixed signs with carry and zero result: never an overflow.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t4_out_sum", 32'(bus.out_sum), 32'h0000);
        checkOutput("t4_out_flags", 32'(bus.out_flags), 32'b1010);
        checkOutput("t4_ovf_count", 32'(bus.ovf_count), 32'd1);
        tick();

        // Backpressure: two entries fill the stage, the third waits upstream.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0002, 1'b0);
        tick();
        checkOutput("t5_in_ready_full", 32'(bus.in_ready), 32'd0);
        checkOutput("t5_head_sum", 32'(bus.out_sum), 32'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0003, 1'b0);
        tick();
        tick();
        checkOutput("t5_hold_sum", 32'(bus.out_sum), 32'h0001);
        checkOutput("t5_hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t5_hold_ready", 32'(bus.in_ready), 32'd0);
        popLog.delete();
        bus.out_ready = 1'b1;
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("t5_drain_count", 32'(popLog.size()), 32'd3);
        for (int i = 0; i < 3 && i < popLog.size(); i++)
            checkOutput("t5_drain_order", 32'(popLog[i]), 32'(i + 1));

        // 300 overflows saturate the counter.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h8000, 1'b0);
        repeat (300) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("t6_ovf_sat", 32'(bus.ovf_count), 32'hFF);

        // Asynchronous reset with two entries buffered.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h000A, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h000B, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("t1_ovf_count", 32'(bus.ovf_count), 32'd0);
        checkOutput("t1_out_sum", 32'(bus.out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t1_recover_sum", 32'(bus.out_sum), 32'hFFFE);
        checkOutput("t1_recover_flags", 32'(bus.out_flags), 32'b0110);
        tick();
        tick();

        compareEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
